uart_rx_fifo: RTL
=================

// Module: uart_rx_fifo
//
// PURPOSE
//   Receive-side byte buffer that sits directly downstream of the UART receiver.
//   - Detects each new received byte from the receiver's level-type rx_full flag
//     and its latched byte output.
//   - Stores bytes in a DEPTH-entry circular FIFO.
//   - Presents them to the consumer on a first-word-fall-through valid/ready port.
//   - Decouples bursty serial arrival from a consumer that may stall.
//   - Records a sticky overflow flag when bytes are lost.
//
// PARAMETERS
//   ADDR_W   4   FIFO address width; DEPTH = 2**ADDR_W entries (ADDR_W >= 1)
//
// PORTS
//   clk        input   1          system clock; all state updates on rising edge
//   rst        input   1          reset; asynchronous, active-low (0 = reset asserted)
//   rx_full    input   1          receiver "byte received" level flag
//   rx_byte    input   8          receiver latched byte; valid whenever rx_full = 1
//   rd_data    output  8          head-of-FIFO byte (FWFT); meaningful when rd_valid = 1
//   rd_valid   output  1          FIFO non-empty
//   rd_ready   input   1          consumer accepts rd_data this cycle
//   count      output  ADDR_W+1   number of stored bytes, 0..DEPTH
//   full       output  1          count == DEPTH
//   overflow   output  1          sticky: at least one byte dropped because FIFO was full
//   ovf_clr    input   1          synchronous clear of overflow
//
// BEHAVIOUR
//   Clocking and reset
//   - One clock; reset is asynchronous and active-low.
//   - While rst = 0: wr_ptr, rd_ptr, count = 0; rd_valid = 0; full = 0; overflow = 0;
//     edge register rx_full_q = 1.
//   - Storage array is not reset; rd_data content is don't-care while rd_valid = 0.
//   - rx_full_q resets to 1: an rx_full held high across reset release is never
//     treated as a new byte.
//
//   Push (input side)
//   - push = rx_full & ~rx_full_q; rx_full_q <= rx_full every cycle.
//   - One push per 0->1 transition of rx_full.
//   - On a push edge: mem[wr_ptr] <= rx_byte; wr_ptr increments.
//
//   Pop (output side)
//   - pop = rd_valid & rd_ready; rd_ready while rd_valid = 0 is ignored.
//   - On pop: rd_ptr increments.
//   - rd_data = mem[rd_ptr], combinational from storage (no read latency).
//
//   Latency and pointers
//   - Byte pushed at edge N is on rd_data with rd_valid = 1 immediately after edge N.
//   - Byte visible one cycle after rx_full is first sampled high.
//   - Pointers are ADDR_W bits and wrap modulo DEPTH with no special handling.
//   - count changes: +1 on push only, -1 on pop only, unchanged on both or neither.
//
//   Boundary conditions
//   - Full, push, no pop: byte dropped; pointers and count unchanged; overflow <= 1.
//   - Full, push and pop in the same cycle: both proceed; count stays DEPTH;
//     no overflow.
//   - Empty, push and rd_ready in the same cycle: pop ignored; push proceeds;
//     count becomes 1.
//   - ovf_clr and a new overflow in the same cycle: set wins (overflow = 1).
//   - Otherwise ovf_clr drives overflow to 0 at the next edge.
//   - Reset asserted mid-operation: all stored bytes are discarded
//     (count = 0 asynchronously).
//   - rd_valid, full and count are derived from count registers only
//     (no combinational path from rd_ready).
//
// TESTING
//   1. Reset release with rx_full = 1 held -> no push; count = 0; rd_valid = 0.
//   2. Single byte: rx_full 0->1 with rx_byte = 8'hA5, rd_ready = 0
//      -> next cycle rd_valid = 1, rd_data = 8'hA5, count = 1.
//      Then rd_ready = 1 for one cycle -> count = 0.
//   3. Order and wrap (ADDR_W = 2): push 8'h01..8'h03, pop 2, push 8'h04..8'h06
//      -> pops return 01,02,03,04,05,06 in order; full asserted at count = 4.
//   4. Overflow (ADDR_W = 2): push 5 bytes 10..14 with no pops
//      -> count = 4, overflow = 1, pops return 10..13.
//      ovf_clr pulse -> overflow = 0.
//   5. Full with simultaneous push and pop: count stays 4; overflow stays 0;
//      pushed byte emerges last.
//   6. Reset mid-stream with count = 3 -> count = 0 and rd_valid = 0 immediately
//      after rst falls; next push yields count = 1 with the new byte.

Source files
------------

// File: rtl/uart_rx_fifo.sv
// rtl/uart_rx_fifo.sv - receive-side byte FIFO fed by a UART receiver's level flag
//
// Purpose:
//   Detects each new byte from the receiver's level-type rx_full flag and
//   buffers bytes in a 2**ADDR_W entry circular FIFO. The bytes are presented
//   first-word-fall-through on a valid/ready port. A sticky overflow flag
//   records any byte dropped while the FIFO was full.
//
// Ports:
//   clk       in   system clock, rising edge
//   rst       in   asynchronous active-low reset
//   rx_full   in   receiver "byte received" level flag
//   rx_byte   in   receiver latched byte, valid while rx_full = 1
//   rd_data   out  head-of-FIFO byte, meaningful while rd_valid = 1
//   rd_valid  out  FIFO non-empty
//   rd_ready  in   consumer accepts rd_data this cycle
//   count     out  stored byte count, 0..DEPTH
//   full      out  count == DEPTH
//   overflow  out  sticky byte-dropped flag
//   ovf_clr   in   synchronous clear of overflow (a same-cycle drop wins)
module uart_rx_fifo #(
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rx_full,
    input  logic [7:0]        rx_byte,
    output logic [7:0]        rd_data,
    output logic              rd_valid,
    input  logic              rd_ready,
    output logic [ADDR_W:0]   count,
    output logic              full,
    output logic              overflow,
    input  logic              ovf_clr
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic              rx_full_q, rx_full_d;
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic              overflow_q, overflow_d;
    logic [7:0]        mem_q [DEPTH];

    logic push;
    logic pop;
    logic wr_en;
    logic drop;

    // Status comes from the count register alone, so rd_ready never reaches
    // rd_valid/full/count combinationally. count never exceeds DEPTH, so its
    // MSB alone marks the full state.
    assign rd_valid = (count_q != '0);
    assign full     = count_q[ADDR_W];
    assign count    = count_q;
    assign overflow = overflow_q;
    assign rd_data  = mem_q[rd_ptr_q];

    always_comb begin
        push       = rx_full & ~rx_full_q;
        pop        = rd_valid & rd_ready;
        // When full, a write is only possible if the head leaves this cycle.
        wr_en      = push & (~full | pop);
        drop       = push & full & ~pop;

        rx_full_d  = rx_full;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q;

        if (wr_en) begin
            wr_ptr_d = wr_ptr_q + ADDR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + ADDR_W'(1);
        end
        if (wr_en && !pop) begin
            count_d = count_q + (ADDR_W+1)'(1);
        end else if (pop && !wr_en) begin
            count_d = count_q - (ADDR_W+1)'(1);
        end

        if (drop) begin
            overflow_d = 1'b1;
        end else if (ovf_clr) begin
            overflow_d = 1'b0;
        end
    end

    // rx_full_q resets high so a flag already set at reset release is not
    // mistaken for a fresh byte.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_full_q  <= 1'b1;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            rx_full_q  <= rx_full_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    // Storage is deliberately not reset; rd_data is don't-care while empty.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_ptr_q] <= rx_byte;
        end
    end

endmodule
